// File: rtl/palette_loader.sv
// Palette write-port loader: packs 4-byte {index, Y, Cb, Cr} entries into one 10-bit 4:3:3 palette write.
// Strobe lands the cycle after the Cr byte; byte_ready_out drops in IDLE and for the single WRITE cycle.
module palette_loader #(
  parameter int PALETTE_DEPTH = 16,
  localparam int IW = $clog2(PALETTE_DEPTH)
) (
  input  logic          clock_in,
  input  logic          reset_n_in,
  input  logic          start_in,
  input  logic          end_in,
  input  logic          data_valid_in,
  input  logic [7:0]    data_in,
  output logic          byte_ready_out,
  output logic          assign_color_enable_out,
  output logic [IW-1:0] assign_color_index_out,
  output logic [9:0]    assign_color_value_out,
  output logic [4:0]    entries_written_out,
  output logic          busy_out,
  output logic          partial_entry_error_out,
  output logic          index_error_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_INDEX, S_GET_Y, S_GET_CB, S_GET_CR, S_WRITE
  } state_t;

  localparam logic [8:0] DEPTH_W = 9'(PALETTE_DEPTH);

  state_t          state_q, state_d;
  logic            end_pend_q, end_pend_d;
  logic [7:0]      idx_q, idx_d;
  logic [3:0]      y_q, y_d;
  logic [2:0]      cb_q, cb_d;
  logic            en_q, en_d;
  logic [IW-1:0]   cidx_q, cidx_d;
  logic [9:0]      cval_q, cval_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            perr_q, perr_d;
  logic            ierr_q, ierr_d;
  logic            getting;
  logic            accept;

  assign getting = (state_q == S_GET_INDEX) || (state_q == S_GET_Y) ||
                   (state_q == S_GET_CB)    || (state_q == S_GET_CR);
  assign accept  = getting && data_valid_in;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= S_IDLE;
      end_pend_q <= 1'b0;
      idx_q      <= '0;
      y_q        <= '0;
      cb_q       <= '0;
      en_q       <= 1'b0;
      cidx_q     <= '0;
      cval_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
      ierr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      end_pend_q <= end_pend_d;
      idx_q      <= idx_d;
      y_q        <= y_d;
      cb_q       <= cb_d;
      en_q       <= en_d;
      cidx_q     <= cidx_d;
      cval_q     <= cval_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      perr_q     <= perr_d;
      ierr_q     <= ierr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    end_pend_d = end_pend_q;
    idx_d      = idx_q;
    y_d        = y_q;
    cb_d       = cb_q;
    en_d       = 1'b0;
    cidx_d     = cidx_q;
    cval_d     = cval_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    perr_d     = perr_q;
    ierr_d     = ierr_q;

    case (state_q)
      S_GET_INDEX: if (accept) begin idx_d = data_in;      state_d = S_GET_Y;  end
      S_GET_Y:     if (accept) begin y_d   = data_in[7:4]; state_d = S_GET_CB; end
      S_GET_CB:    if (accept) begin cb_d  = data_in[7:5]; state_d = S_GET_CR; end
      S_GET_CR: begin
        if (accept) begin
          state_d    = S_WRITE;
          end_pend_d = end_in;
          if ({1'b0, idx_q} < DEPTH_W) begin
            en_d   = 1'b1;
            cidx_d = idx_q[IW-1:0];
            cval_d = {y_q, cb_q, data_in[7:5]};
            if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
          end else begin
            ierr_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        end_pend_d = 1'b0;
        if (end_pend_q || end_in) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_GET_INDEX;
        end
      end
      default: ;
    endcase

    // end_in is judged after this cycle's byte: a completed entry is not an error
    if (end_in && getting && !(state_q == S_GET_CR && accept)) begin
      if (state_d != S_GET_INDEX) perr_d = 1'b1;
      state_d = S_IDLE;
      busy_d  = 1'b0;
      idx_d   = '0;
      y_d     = '0;
      cb_d    = '0;
    end

    if (start_in) begin
      state_d    = S_GET_INDEX;
      end_pend_d = 1'b0;
      busy_d     = 1'b1;
      cnt_d      = '0;
      perr_d     = 1'b0;
      ierr_d     = 1'b0;
      en_d       = 1'b0;
      cidx_d     = cidx_q;
      cval_d     = cval_q;
      idx_d      = '0;
      y_d        = '0;
      cb_d       = '0;
    end
  end

  assign byte_ready_out          = getting;
  assign assign_color_enable_out = en_q;
  assign assign_color_index_out  = cidx_q;
  assign assign_color_value_out  = cval_q;
  assign entries_written_out     = cnt_q;
  assign busy_out                = busy_q;
  assign partial_entry_error_out = perr_q;
  assign index_error_out         = ierr_q;

endmodule

// File: tb/tb_palette_loader.sv
// Directed table-driven bench for palette_loader plus hand-written burst and reset sequences.
module tb_palette_loader;
  logic       clock_in = 1'b0;
  logic       reset_n_in = 1'b0;
  logic       start_in = 1'b0;
  logic       end_in = 1'b0;
  logic       data_valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       byte_ready_out;
  logic       assign_color_enable_out;
  logic [3:0] assign_color_index_out;
  logic [9:0] assign_color_value_out;
  logic [4:0] entries_written_out;
  logic       busy_out;
  logic       partial_entry_error_out;
  logic       index_error_out;

  int n_cmp = 0;
  int n_bad = 0;

  palette_loader #(.PALETTE_DEPTH(16)) dut (
    .clock_in(clock_in),
    .reset_n_in(reset_n_in),
    .start_in(start_in),
    .end_in(end_in),
    .data_valid_in(data_valid_in),
    .data_in(data_in),
    .byte_ready_out(byte_ready_out),
    .assign_color_enable_out(assign_color_enable_out),
    .assign_color_index_out(assign_color_index_out),
    .assign_color_value_out(assign_color_value_out),
    .entries_written_out(entries_written_out),
    .busy_out(busy_out),
    .partial_entry_error_out(partial_entry_error_out),
    .index_error_out(index_error_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic        st;
    logic        en;
    logic        dv;
    logic [7:0]  d;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];

  // packed order: {rdy, strobe, index[3:0], value[9:0], count[4:0], busy, partial_err, index_err}
  function automatic logic [23:0] ex(input logic rdy, input logic en, input logic [3:0] idx,
                                     input logic [9:0] val, input logic [4:0] cnt,
                                     input logic busy, input logic perr, input logic ierr);
    return {rdy, en, idx, val, cnt, busy, perr, ierr};
  endfunction

  task automatic check(input string nm, input int k, input logic [23:0] exp);
    logic [23:0] obs;
    obs = {byte_ready_out, assign_color_enable_out, assign_color_index_out,
           assign_color_value_out, entries_written_out, busy_out,
           partial_entry_error_out, index_error_out};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, k, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic en, input logic dv, input logic [7:0] d);
    start_in      = st;
    end_in        = en;
    data_valid_in = dv;
    data_in       = d;
  endtask

  task automatic add(input logic st, input logic en, input logic dv, input logic [7:0] d,
                     input logic [23:0] e);
    vec_t v;
    v.st = st; v.en = en; v.dv = dv; v.d = d; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] pidx;
    logic [9:0] pval;
    logic [9:0] v;
    logic [3:0] i4;
    logic [7:0] bytes [4];

    #3;
    check("reset", 0, 24'h0);
    @(negedge clock_in);
    reset_n_in = 1'b1;

    // single entry index 3
    add(1,0,0,8'h00, ex(1,0,4'h0,10'h000,0,1,0,0));
    add(0,0,1,8'h03, ex(1,0,4'h0,10'h000,0,1,0,0));
    add(0,0,1,8'hF0, ex(1,0,4'h0,10'h000,0,1,0,0));
    add(0,0,1,8'h80, ex(1,0,4'h0,10'h000,0,1,0,0));
    add(0,0,1,8'h80, ex(0,1,4'h3,10'h3E4,1,1,0,0));
    add(0,1,0,8'h00, ex(0,0,4'h3,10'h3E4,1,0,0,0));
    // bad index then good index 1
    add(1,0,0,8'h00, ex(1,0,4'h3,10'h3E4,0,1,0,0));
    add(0,0,1,8'h12, ex(1,0,4'h3,10'h3E4,0,1,0,0));
    add(0,0,1,8'hFF, ex(1,0,4'h3,10'h3E4,0,1,0,0));
    add(0,0,1,8'hFF, ex(1,0,4'h3,10'h3E4,0,1,0,0));
    add(0,0,1,8'hFF, ex(0,0,4'h3,10'h3E4,0,1,0,1));
    add(0,0,0,8'h00, ex(1,0,4'h3,10'h3E4,0,1,0,1));
    add(0,0,1,8'h01, ex(1,0,4'h3,10'h3E4,0,1,0,1));
    add(0,0,1,8'h00, ex(1,0,4'h3,10'h3E4,0,1,0,1));
    add(0,0,1,8'h20, ex(1,0,4'h3,10'h3E4,0,1,0,1));
    add(0,0,1,8'hE0, ex(0,1,4'h1,10'h00F,1,1,0,1));
    add(0,1,0,8'h00, ex(0,0,4'h1,10'h00F,1,0,0,1));
    // partial entry, then flags held in idle, then cleared by start
    add(1,0,0,8'h00, ex(1,0,4'h1,10'h00F,0,1,0,0));
    add(0,0,1,8'h05, ex(1,0,4'h1,10'h00F,0,1,0,0));
    add(0,0,1,8'hAA, ex(1,0,4'h1,10'h00F,0,1,0,0));
    add(0,1,0,8'h00, ex(0,0,4'h1,10'h00F,0,0,1,0));
    add(0,0,1,8'h77, ex(0,0,4'h1,10'h00F,0,0,1,0));
    add(1,0,0,8'h00, ex(1,0,4'h1,10'h00F,0,1,0,0));
    // restart mid-entry, then index 7
    add(0,0,1,8'h33, ex(1,0,4'h1,10'h00F,0,1,0,0));
    add(0,0,1,8'h44, ex(1,0,4'h1,10'h00F,0,1,0,0));
    add(1,0,0,8'h00, ex(1,0,4'h1,10'h00F,0,1,0,0));
    add(0,0,1,8'h07, ex(1,0,4'h1,10'h00F,0,1,0,0));
    add(0,0,1,8'h10, ex(1,0,4'h1,10'h00F,0,1,0,0));
    add(0,0,1,8'h20, ex(1,0,4'h1,10'h00F,0,1,0,0));
    add(0,0,1,8'h30, ex(0,1,4'h7,10'h049,1,1,0,0));
    add(0,0,0,8'h00, ex(1,0,4'h7,10'h049,1,1,0,0));
    add(0,1,0,8'h00, ex(0,0,4'h7,10'h049,1,0,0,0));
    // Cr together with end_in
    add(1,0,0,8'h00, ex(1,0,4'h7,10'h049,0,1,0,0));
    add(0,0,1,8'h09, ex(1,0,4'h7,10'h049,0,1,0,0));
    add(0,0,1,8'h80, ex(1,0,4'h7,10'h049,0,1,0,0));
    add(0,0,1,8'h40, ex(1,0,4'h7,10'h049,0,1,0,0));
    add(0,1,1,8'hC0, ex(0,1,4'h9,10'h216,1,1,0,0));
    add(0,0,0,8'h00, ex(0,0,4'h9,10'h216,1,0,0,0));
    // start and end together: start wins; end on an empty entry is clean
    add(1,1,0,8'h00, ex(1,0,4'h9,10'h216,0,1,0,0));
    add(0,1,0,8'h00, ex(0,0,4'h9,10'h216,0,0,0,0));
    // index byte accepted with end_in leaves one held byte
    add(1,0,0,8'h00, ex(1,0,4'h9,10'h216,0,1,0,0));
    add(0,1,1,8'h02, ex(0,0,4'h9,10'h216,0,0,1,0));
    // start during WRITE: the write shows, count restarts
    add(1,0,0,8'h00, ex(1,0,4'h9,10'h216,0,1,0,0));
    add(0,0,1,8'h0A, ex(1,0,4'h9,10'h216,0,1,0,0));
    add(0,0,1,8'h00, ex(1,0,4'h9,10'h216,0,1,0,0));
    add(0,0,1,8'h00, ex(1,0,4'h9,10'h216,0,1,0,0));
    add(0,0,1,8'h00, ex(0,1,4'hA,10'h000,1,1,0,0));
    add(1,0,0,8'h00, ex(1,0,4'hA,10'h000,0,1,0,0));
    add(0,1,0,8'h00, ex(0,0,4'hA,10'h000,0,0,0,0));

    foreach (tbl[k]) begin
      drive(tbl[k].st, tbl[k].en, tbl[k].dv, tbl[k].d);
      @(negedge clock_in);
      check("tbl", k, tbl[k].exp);
    end

    // 16 back-to-back entries with data_valid held high
    drive(1,0,0,8'h00);
    @(negedge clock_in);
    check("burst_start", 0, ex(1,0,4'hA,10'h000,0,1,0,0));
    pidx = 4'hA;
    pval = 10'h000;
    for (int i = 0; i < 16; i++) begin
      i4 = 4'(i);
      bytes[0] = {4'h0, i4};
      bytes[1] = {i4, 4'hA};
      bytes[2] = {i4[2:0], 5'h1F};
      bytes[3] = {~i4[2:0], 5'h00};
      v = {i4, i4[2:0], ~i4[2:0]};
      for (int b = 0; b < 4; b++) begin
        drive(0,0,1,bytes[b]);
        @(negedge clock_in);
        if (b < 3) check("burst_byte", i*4+b, ex(1,0,pidx,pval,5'(i),1,0,0));
        else       check("burst_write", i, ex(0,1,i4,v,5'(i+1),1,0,0));
      end
      drive(0,0,1,8'hEE);
      @(negedge clock_in);
      check("burst_after", i, ex(1,0,i4,v,5'(i+1),1,0,0));
      pidx = i4;
      pval = v;
    end
    drive(0,1,0,8'h00);
    @(negedge clock_in);
    check("burst_end", 0, ex(0,0,4'hF,pval,5'd16,0,0,0));

    // asynchronous reset while waiting for Cb
    drive(1,0,0,8'h00);
    @(negedge clock_in);
    check("rst_seq", 0, ex(1,0,4'hF,pval,0,1,0,0));
    drive(0,0,1,8'h01);
    @(negedge clock_in);
    drive(0,0,1,8'h02);
    @(negedge clock_in);
    check("rst_seq", 1, ex(1,0,4'hF,pval,0,1,0,0));
    drive(0,0,1,8'h55);
    #2;
    reset_n_in = 1'b0;
    #1;
    check("rst_async", 0, 24'h0);
    @(negedge clock_in);
    check("rst_async", 1, 24'h0);
    reset_n_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock_in);
      check("rst_after", c, 24'h0);
    end
    drive(0,0,0,8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
